// File: rtl/bus_arb_pkg.sv
// Shared types for the two-master memory arbiter: FSM state encoding and master identifiers.
package bus_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    typedef logic master_id_t;

endpackage

// File: rtl/bus_mem_arbiter_arb_rr2.sv
// Two-input round-robin picker: on a tie the master that did not own the last burst wins.
module arb_rr2
    import bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       pick
);

    always_comb begin
        valid = |req;
        pick  = 1'b0;
        if (req == 2'b11) begin
            pick = ~last;
        end else begin
            pick = req[1];
        end
    end

endmodule

// File: rtl/bus_mem_arbiter.sv
// Round-robin arbiter that owns one memory slave per burst, walks the burst address
// beat by beat, range-checks each beat and registers read data back to the owner.
module bus_mem_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int MEM_DEPTH  = 128
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [LEN_WIDTH-1:0]  m0_len,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [LEN_WIDTH-1:0]  m1_len,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  s_wen,
    output logic                  s_ren,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [DATA_WIDTH-1:0] s_rdata
);

    // One extra bit so a depth equal to the full address space compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);

    state_t                state_reg, state_next;
    master_id_t            owner_reg, owner_next;
    master_id_t            last_reg, last_next;
    logic [LEN_WIDTH-1:0]  beat_reg, beat_next;
    logic [LEN_WIDTH-1:0]  len_reg, len_next;
    logic [ADDR_WIDTH-1:0] base_reg, base_next;
    logic                  wr_reg, wr_next;

    logic [1:0]            req_vec;
    logic                  arb_valid;
    master_id_t            arb_pick;
    logic                  xfer;
    logic                  owner_req;
    logic [DATA_WIDTH-1:0] owner_wdata;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  in_range;
    logic                  ack;
    logic                  perform;

    logic [NUM_MASTERS-1:0] gnt_vec, ack_vec, err_vec, rvalid_vec;
    logic [DATA_WIDTH-1:0]  rdata_arr [NUM_MASTERS];

    assign req_vec = {m1_req, m0_req};

    arb_rr2 u_arb (
        .req   (req_vec),
        .last  (last_reg),
        .valid (arb_valid),
        .pick  (arb_pick)
    );

    assign xfer        = (state_reg == XFER);
    assign owner_req   = owner_reg ? m1_req : m0_req;
    assign owner_wdata = owner_reg ? m1_wdata : m0_wdata;
    assign beat_addr   = base_reg + {{(ADDR_WIDTH-LEN_WIDTH){1'b0}}, beat_reg};
    assign in_range    = ({1'b0, beat_addr} < DEPTH_LIM);
    assign ack         = xfer && owner_req;
    assign perform     = ack && in_range;

    assign s_wen   = perform && wr_reg;
    assign s_ren   = perform && !wr_reg;
    assign s_addr  = perform ? beat_addr : '0;
    assign s_wdata = perform ? owner_wdata : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            beat_reg  <= '0;
            len_reg   <= '0;
            base_reg  <= '0;
            wr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            beat_reg  <= beat_next;
            len_reg   <= len_next;
            base_reg  <= base_next;
            wr_reg    <= wr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        beat_next  = beat_reg;
        len_next   = len_reg;
        base_next  = base_reg;
        wr_next    = wr_reg;
        case (state_reg)
            IDLE: begin
                if (arb_valid) begin
                    state_next = XFER;
                    owner_next = arb_pick;
                    base_next  = arb_pick ? m1_addr : m0_addr;
                    len_next   = arb_pick ? m1_len : m0_len;
                    wr_next    = arb_pick ? m1_wr : m0_wr;
                    beat_next  = '0;
                end
            end
            XFER: begin
                // A dropped request aborts the burst just like a completed one.
                if (!owner_req || (beat_reg == len_reg)) begin
                    state_next = IDLE;
                    last_next  = owner_reg;
                end else begin
                    beat_next = beat_reg + LEN_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            logic                  is_owner;
            logic                  rvalid_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;

            assign is_owner = (owner_reg == master_id_t'(gi));

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= s_ren && is_owner;
                    if (s_ren && is_owner) begin
                        rdata_reg <= s_rdata;
                    end
                end
            end

            assign gnt_vec[gi]    = xfer && is_owner;
            assign ack_vec[gi]    = ack && is_owner;
            assign err_vec[gi]    = ack && !in_range && is_owner;
            assign rvalid_vec[gi] = rvalid_reg;
            assign rdata_arr[gi]  = rdata_reg;
        end
    endgenerate

    assign m0_gnt    = gnt_vec[0];
    assign m0_ack    = ack_vec[0];
    assign m0_err    = err_vec[0];
    assign m0_rvalid = rvalid_vec[0];
    assign m0_rdata  = rdata_arr[0];
    assign m1_gnt    = gnt_vec[1];
    assign m1_ack    = ack_vec[1];
    assign m1_err    = err_vec[1];
    assign m1_rvalid = rvalid_vec[1];
    assign m1_rdata  = rdata_arr[1];

endmodule
